// File: rtl/timer_rst_seq_ctrl.sv
// Reset sequencer for the timer IP: merges POR/SW/WDT reset requests, stretches
// the reset, then releases register bank, counter and interrupt logic in order.
module timer_rst_seq_ctrl #(
  parameter int CNT_W       = 8,
  parameter int STRETCH_CYC = 4,
  parameter int GAP_CYC     = 2
) (
  input  logic       sys_clk,
  input  logic       sys_resetn,
  input  logic       sw_rst_req,
  input  logic       wdt_rst_req,
  output logic       core_rstn,
  output logic       cnt_rstn,
  output logic       irq_rstn,
  output logic       clk_en,
  output logic       rst_busy,
  output logic       rst_done,
  output logic [1:0] rst_cause
);

  typedef enum logic [1:0] {
    HOLD,
    REL_CORE,
    REL_CNT,
    RUN
  } state_t;

  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             sw_prev, wdt_prev;
  logic             sw_edge, wdt_edge;
  logic [1:0]       cause_nxt;
  logic             done_nxt;

  assign sw_edge  = sw_rst_req  & ~sw_prev;
  assign wdt_edge = wdt_rst_req & ~wdt_prev;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_ONE;
    cause_nxt = rst_cause;
    done_nxt  = 1'b0;
    unique case (state)
      HOLD: begin
        if (cnt == STRETCH_LAST) begin
          state_nxt = REL_CORE;
          cnt_nxt   = '0;
        end
      end
      REL_CORE: begin
        if (cnt == GAP_LAST) begin
          state_nxt = REL_CNT;
          cnt_nxt   = '0;
        end
      end
      REL_CNT: begin
        if (cnt == GAP_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
        end
      end
      RUN: begin
        // Counter is parked in RUN so it can never wrap while idle.
        cnt_nxt = '0;
        if (wdt_edge) begin
          state_nxt = HOLD;
          cause_nxt = CAUSE_WDT;
        end else if (sw_edge) begin
          state_nxt = HOLD;
          cause_nxt = CAUSE_SW;
        end
      end
      default: begin
        state_nxt = HOLD;
        cnt_nxt   = '0;
      end
    endcase
    // Watchdog restarts an in-flight sequence; a software edge there is dropped.
    if (state != RUN && wdt_edge) begin
      state_nxt = HOLD;
      cnt_nxt   = '0;
      cause_nxt = CAUSE_WDT;
      done_nxt  = 1'b0;
    end
  end

  // Outputs are registered from the next state so they change on the entry edge.
  always_ff @(posedge sys_clk) begin
    if (!sys_resetn) begin
      state     <= HOLD;
      cnt       <= '0;
      sw_prev   <= 1'b1;
      wdt_prev  <= 1'b1;
      core_rstn <= 1'b0;
      cnt_rstn  <= 1'b0;
      irq_rstn  <= 1'b0;
      clk_en    <= 1'b0;
      rst_busy  <= 1'b1;
      rst_done  <= 1'b0;
      rst_cause <= CAUSE_POR;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sw_prev   <= sw_rst_req;
      wdt_prev  <= wdt_rst_req;
      core_rstn <= (state_nxt != HOLD);
      cnt_rstn  <= (state_nxt == REL_CNT) || (state_nxt == RUN);
      irq_rstn  <= (state_nxt == RUN);
      clk_en    <= (state_nxt == RUN);
      rst_busy  <= (state_nxt != RUN);
      rst_done  <= done_nxt;
      rst_cause <= cause_nxt;
    end
  end

endmodule

// File: tb/tb_timer_rst_seq_ctrl.sv
// Directed bench for timer_rst_seq_ctrl: default (4,2) instance plus a (1,1) instance.
module tb_timer_rst_seq_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_resetn = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic       wdt_rst_req = 1'b0;

  logic       core_rstn, cnt_rstn, irq_rstn, clk_en, rst_busy, rst_done;
  logic [1:0] rst_cause;
  logic       f_core_rstn, f_cnt_rstn, f_irq_rstn, f_clk_en, f_rst_busy, f_rst_done;
  logic [1:0] f_rst_cause;

  int errors = 0;
  int checks = 0;

  always #5 sys_clk = ~sys_clk;

  timer_rst_seq_ctrl #(.CNT_W(8), .STRETCH_CYC(4), .GAP_CYC(2)) u_dut (
    .sys_clk(sys_clk), .sys_resetn(sys_resetn),
    .sw_rst_req(sw_rst_req), .wdt_rst_req(wdt_rst_req),
    .core_rstn(core_rstn), .cnt_rstn(cnt_rstn), .irq_rstn(irq_rstn),
    .clk_en(clk_en), .rst_busy(rst_busy), .rst_done(rst_done),
    .rst_cause(rst_cause)
  );

  timer_rst_seq_ctrl #(.CNT_W(8), .STRETCH_CYC(1), .GAP_CYC(1)) u_fast (
    .sys_clk(sys_clk), .sys_resetn(sys_resetn),
    .sw_rst_req(sw_rst_req), .wdt_rst_req(wdt_rst_req),
    .core_rstn(f_core_rstn), .cnt_rstn(f_cnt_rstn), .irq_rstn(f_irq_rstn),
    .clk_en(f_clk_en), .rst_busy(f_rst_busy), .rst_done(f_rst_done),
    .rst_cause(f_rst_cause)
  );

  logic [5:0] vec, f_vec;
  assign vec   = {core_rstn, cnt_rstn, irq_rstn, clk_en, rst_busy, rst_done};
  assign f_vec = {f_core_rstn, f_cnt_rstn, f_irq_rstn, f_clk_en, f_rst_busy, f_rst_done};

  // Expected {core,cnt,irq,clk_en,busy,done} k edges after entry edge.
  function automatic logic [5:0] exp_vec(input int k, input int s, input int g);
    logic [5:0] v;
    v[5] = (k >= s);
    v[4] = (k >= s + g);
    v[3] = (k >= s + 2 * g);
    v[2] = (k >= s + 2 * g);
    v[1] = (k <  s + 2 * g);
    v[0] = (k == s + 2 * g);
    return v;
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Release-order invariant on both instances.
  always @(negedge sys_clk) begin
    if (sys_resetn) begin
      checks++;
      if ((irq_rstn & ~cnt_rstn) || (cnt_rstn & ~core_rstn) ||
          (clk_en & ~(core_rstn & cnt_rstn & irq_rstn))) begin
        errors++;
        $display("FAIL order_dut: got core/cnt/irq/en=%b%b%b%b", core_rstn, cnt_rstn, irq_rstn, clk_en);
      end
      checks++;
      if ((f_irq_rstn & ~f_cnt_rstn) || (f_cnt_rstn & ~f_core_rstn) ||
          (f_clk_en & ~(f_core_rstn & f_cnt_rstn & f_irq_rstn))) begin
        errors++;
        $display("FAIL order_fast: got core/cnt/irq/en=%b%b%b%b", f_core_rstn, f_cnt_rstn, f_irq_rstn, f_clk_en);
      end
    end
  end

  task automatic test_reset();
    int dones = 0;
    sys_resetn = 1'b0; sw_rst_req = 1'b0; wdt_rst_req = 1'b0;
    repeat (3) tick();
    checks++;
    if (vec !== 6'b000010 || rst_cause !== 2'b00) begin
      errors++;
      $display("FAIL reset_values: got vec=%b cause=%b expected vec=000010 cause=00", vec, rst_cause);
    end
    sys_resetn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (rst_done === 1'b1) dones++;
      checks++;
      if (vec !== exp_vec(k, 4, 2)) begin
        errors++;
        $display("FAIL por_seq k=%0d: got %b expected %b", k, vec, exp_vec(k, 4, 2));
      end
    end
    checks++;
    if (rst_cause !== 2'b00 || dones != 1) begin
      errors++;
      $display("FAIL por_cause: got cause=%b dones=%0d expected cause=00 dones=1", rst_cause, dones);
    end
  endtask

  task automatic test_sw_reset();
    sw_rst_req = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      tick();
      checks++;
      if (vec !== exp_vec(k, 4, 2)) begin
        errors++;
        $display("FAIL sw_seq k=%0d: got %b expected %b", k, vec, exp_vec(k, 4, 2));
      end
    end
    checks++;
    if (rst_cause !== 2'b01) begin
      errors++;
      $display("FAIL sw_cause: got %b expected 01", rst_cause);
    end
    sw_rst_req = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    int dones = 0;
    sw_rst_req = 1'b1; wdt_rst_req = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      tick();
      if (rst_done === 1'b1) dones++;
      checks++;
      if (vec !== exp_vec(k, 4, 2)) begin
        errors++;
        $display("FAIL simul_seq k=%0d: got %b expected %b", k, vec, exp_vec(k, 4, 2));
      end
    end
    checks++;
    if (rst_cause !== 2'b10 || dones != 1) begin
      errors++;
      $display("FAIL simul_cause: got cause=%b dones=%0d expected cause=10 dones=1", rst_cause, dones);
    end
    sw_rst_req = 1'b0; wdt_rst_req = 1'b0;
    tick();
  endtask

  task automatic test_wdt_restart();
    sw_rst_req = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      tick();
      checks++;
      if (vec !== exp_vec(k, 4, 2)) begin
        errors++;
        $display("FAIL wdt_pre k=%0d: got %b expected %b", k, vec, exp_vec(k, 4, 2));
      end
    end
    wdt_rst_req = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      tick();
      checks++;
      if (vec !== exp_vec(k, 4, 2)) begin
        errors++;
        $display("FAIL wdt_restart k=%0d: got %b expected %b", k, vec, exp_vec(k, 4, 2));
      end
    end
    checks++;
    if (rst_cause !== 2'b10) begin
      errors++;
      $display("FAIL wdt_restart_cause: got %b expected 10", rst_cause);
    end
    sw_rst_req = 1'b0; wdt_rst_req = 1'b0;
    tick();
  endtask

  task automatic test_sw_ignored();
    sw_rst_req = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      tick();
      checks++;
      if (vec !== exp_vec(k, 4, 2)) begin
        errors++;
        $display("FAIL sw_ignored k=%0d: got %b expected %b", k, vec, exp_vec(k, 4, 2));
      end
      if (k == 0) sw_rst_req = 1'b0;
      if (k == 4) sw_rst_req = 1'b1;
    end
    checks++;
    if (rst_cause !== 2'b01) begin
      errors++;
      $display("FAIL sw_ignored_cause: got %b expected 01", rst_cause);
    end
    sw_rst_req = 1'b0;
    tick();
  endtask

  task automatic test_mid_reset();
    sw_rst_req = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      tick();
      checks++;
      if (vec !== exp_vec(k, 4, 2)) begin
        errors++;
        $display("FAIL mid_pre k=%0d: got %b expected %b", k, vec, exp_vec(k, 4, 2));
      end
    end
    sys_resetn = 1'b0;
    tick();
    checks++;
    if (vec !== 6'b000010 || rst_cause !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset: got vec=%b cause=%b expected vec=000010 cause=00", vec, rst_cause);
    end
    // sw_rst_req stays high through reset and must not trigger afterwards.
    sys_resetn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++;
      if (vec !== exp_vec(k, 4, 2)) begin
        errors++;
        $display("FAIL mid_restart k=%0d: got %b expected %b", k, vec, exp_vec(k, 4, 2));
      end
    end
    checks++;
    if (rst_cause !== 2'b00) begin
      errors++;
      $display("FAIL mid_cause: got %b expected 00", rst_cause);
    end
    sw_rst_req = 1'b0;
    tick();
  endtask

  task automatic test_fast_params();
    sys_resetn = 1'b0;
    repeat (2) tick();
    checks++;
    if (f_vec !== 6'b000010) begin
      errors++;
      $display("FAIL fast_reset: got %b expected 000010", f_vec);
    end
    sys_resetn = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (f_vec !== exp_vec(k, 1, 1)) begin
        errors++;
        $display("FAIL fast_seq k=%0d: got %b expected %b", k, f_vec, exp_vec(k, 1, 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_sw_reset();
    test_simultaneous();
    test_wdt_restart();
    test_sw_ignored();
    test_mid_reset();
    test_fast_params();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
